// File: rtl/pc060ha_pkg.sv
// Shared encodings for the PC060HA master-side sequencer: command ops, register
// indices, flag bit positions and FSM state types.
package pc060ha_pkg;

    typedef enum logic [1:0] {
        OpSend   = 2'd0,
        OpRecv   = 2'd1,
        OpRstSet = 2'd2,
        OpRstClr = 2'd3
    } cmd_op_e;

    localparam logic [3:0] IDX_PAIR0 = 4'd0;
    localparam logic [3:0] IDX_PAIR1 = 4'd2;
    localparam logic [3:0] IDX_CTRL  = 4'd4;

    localparam logic [1:0] FLAG_MPEND0  = 2'd0;
    localparam logic [1:0] FLAG_MPEND1  = 2'd1;
    localparam logic [1:0] FLAG_SAVAIL0 = 2'd2;
    localparam logic [1:0] FLAG_SAVAIL1 = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPollIdx,
        StPollRd,
        StCheck,
        StIdx,
        StD0,
        StD1,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        BcIdle,
        BcSetup,
        BcStrobe,
        BcHold
    } bus_state_e;

    // Flag bit that gates a SEND (master slot pending) or RECV (slave slot available).
    function automatic logic [1:0] flag_pos(input logic is_recv, input logic pair);
        if (is_recv) begin
            return pair ? FLAG_SAVAIL1 : FLAG_SAVAIL0;
        end
        return pair ? FLAG_MPEND1 : FLAG_MPEND0;
    endfunction

endpackage

// File: rtl/pc060ha_bus_cycle.sv
// Runs one PC060HA master-port access: SETUP, STROBE_LEN strobe cycles, HOLD.
// Idle state keeps nMCS high, which provides the inter-access gap.
module pc060ha_bus_cycle
    import pc060ha_pkg::*;
#(
    parameter int unsigned STROBE_LEN = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       is_write_i,
    input  logic       a0_i,
    input  logic [3:0] wdata_i,
    output logic       idle_o,
    output logic       done_o,
    output logic [3:0] rdata_o,
    output logic       nmcs_o,
    output logic       nmwr_o,
    output logic       nmrd_o,
    output logic       ma0_o,
    output logic [3:0] md_o,
    output logic       md_oe_o,
    input  logic [3:0] md_i
);

    localparam logic [3:0] LastCnt = 4'(STROBE_LEN - 1);

    bus_state_e st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic       a0_q, a0_d;
    logic [3:0] wd_q, wd_d;
    logic [3:0] rd_q, rd_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q  <= BcIdle;
            cnt_q <= 4'd0;
            we_q  <= 1'b0;
            a0_q  <= 1'b0;
            wd_q  <= 4'd0;
            rd_q  <= 4'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            we_q  <= we_d;
            a0_q  <= a0_d;
            wd_q  <= wd_d;
            rd_q  <= rd_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        we_d  = we_q;
        a0_d  = a0_q;
        wd_d  = wd_q;
        rd_d  = rd_q;
        unique case (st_q)
            BcIdle: begin
                if (start_i) begin
                    st_d = BcSetup;
                    we_d = is_write_i;
                    a0_d = a0_i;
                    wd_d = is_write_i ? wdata_i : 4'd0;
                end
            end
            BcSetup: begin
                st_d  = BcStrobe;
                cnt_d = 4'd0;
            end
            BcStrobe: begin
                if (cnt_q == LastCnt) begin
                    st_d = BcHold;
                    if (!we_q) begin
                        rd_d = md_i;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            BcHold:  st_d = BcIdle;
            default: st_d = BcIdle;
        endcase
    end

    always_comb begin
        idle_o  = (st_q == BcIdle);
        done_o  = (st_q == BcHold);
        rdata_o = rd_q;
        nmcs_o  = (st_q == BcIdle);
        nmwr_o  = !((st_q == BcStrobe) && we_q);
        nmrd_o  = !((st_q == BcStrobe) && !we_q);
        ma0_o   = a0_q;
        md_o    = wd_q;
        md_oe_o = we_q && (st_q != BcIdle);
    end

endmodule

// File: rtl/pc060ha_master_seq.sv
// Master-side PC060HA sequencer: turns byte commands into flag polling, index
// writes and nibble data accesses, one bus access at a time.
module pc060ha_master_seq
    import pc060ha_pkg::*;
#(
    parameter int unsigned STROBE_LEN = 2,
    parameter int unsigned POLL_MAX   = 255
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_pair,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       nMCS,
    output logic       nMWR,
    output logic       nMRD,
    output logic       MA0,
    output logic [3:0] MD_O,
    output logic       MD_OE,
    input  logic [3:0] MD_I
);

    state_e     state_q, state_d;
    cmd_op_e    op_q, op_d;
    logic       pair_q, pair_d;
    logic [7:0] data_q, data_d;
    logic [7:0] poll_q, poll_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    logic       bus_start, bus_we, bus_a0, bus_idle, bus_done;
    logic [3:0] bus_wd, bus_rdata;
    logic       is_slave, flag_ok, accept;

    pc060ha_bus_cycle #(
        .STROBE_LEN(STROBE_LEN)
    ) u_bus (
        .clk_i     (MCLK),
        .rst_i     (RESET),
        .start_i   (bus_start),
        .is_write_i(bus_we),
        .a0_i      (bus_a0),
        .wdata_i   (bus_wd),
        .idle_o    (bus_idle),
        .done_o    (bus_done),
        .rdata_o   (bus_rdata),
        .nmcs_o    (nMCS),
        .nmwr_o    (nMWR),
        .nmrd_o    (nMRD),
        .ma0_o     (MA0),
        .md_o      (MD_O),
        .md_oe_o   (MD_OE),
        .md_i      (MD_I)
    );

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            op_q       <= OpSend;
            pair_q     <= 1'b0;
            data_q     <= 8'd0;
            poll_q     <= 8'd0;
            rsp_data_q <= 8'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pair_q     <= pair_d;
            data_q     <= data_d;
            poll_q     <= poll_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign is_slave = (op_q == OpRstSet) || (op_q == OpRstClr);
    assign accept   = cmd_valid && cmd_ready;
    // SEND waits for the master slot to drain; RECV waits for the slave slot to fill.
    assign flag_ok  = (op_q == OpRecv) ? bus_rdata[flag_pos(1'b1, pair_q)]
                                       : !bus_rdata[flag_pos(1'b0, pair_q)];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pair_d     = pair_q;
        data_d     = data_q;
        poll_d     = poll_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d       = cmd_op_e'(cmd_op);
                    pair_d     = cmd_pair;
                    data_d     = cmd_data;
                    poll_d     = 8'd0;
                    rsp_data_d = 8'd0;
                    rsp_err_d  = 1'b0;
                    state_d    = ((cmd_op == OpSend) || (cmd_op == OpRecv)) ? StPollIdx : StIdx;
                end
            end
            StPollIdx: if (bus_done) state_d = StPollRd;
            StPollRd:  if (bus_done) state_d = StCheck;
            StCheck: begin
                poll_d = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;
                if (flag_ok) begin
                    poll_d  = poll_q;
                    state_d = StIdx;
                end else if ((32'(poll_q) + 32'd1) >= POLL_MAX) begin
                    rsp_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    state_d = StPollRd;
                end
            end
            StIdx: if (bus_done) state_d = StD0;
            StD0: begin
                if (bus_done) begin
                    if (op_q == OpRecv) rsp_data_d[3:0] = bus_rdata;
                    state_d = is_slave ? StDone : StD1;
                end
            end
            StD1: begin
                if (bus_done) begin
                    if (op_q == OpRecv) rsp_data_d[7:4] = bus_rdata;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle) && !RESET;
        rsp_valid = (state_q == StDone);
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        bus_start = 1'b0;
        bus_we    = 1'b0;
        bus_a0    = 1'b0;
        bus_wd    = 4'd0;
        unique case (state_q)
            StPollIdx: begin
                bus_start = bus_idle;
                bus_we    = 1'b1;
                bus_wd    = IDX_CTRL;
            end
            StPollRd: begin
                bus_start = bus_idle;
                bus_a0    = 1'b1;
            end
            StIdx: begin
                bus_start = bus_idle;
                bus_we    = 1'b1;
                bus_wd    = is_slave ? IDX_CTRL : (pair_q ? IDX_PAIR1 : IDX_PAIR0);
            end
            StD0: begin
                bus_start = bus_idle;
                bus_a0    = 1'b1;
                bus_we    = (op_q != OpRecv);
                bus_wd    = is_slave ? {3'b000, op_q == OpRstSet} : data_q[3:0];
            end
            StD1: begin
                bus_start = bus_idle;
                bus_a0    = 1'b1;
                bus_we    = (op_q == OpSend);
                bus_wd    = data_q[7:4];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc060ha_master_seq.sv
// Scoreboard bench: a PC060HA slave model answers reads, expected bus accesses and
// responses are queued per command and compared as the DUT produces them.
module tb_pc060ha_master_seq;

    localparam int unsigned SL = 2;
    localparam int unsigned PM = 4;

    logic       MCLK = 1'b0;
    logic       RESET;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_pair;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_data;
    logic       nMCS, nMWR, nMRD, MA0, MD_OE;
    logic [3:0] MD_O, MD_I;

    logic       rst6, cv6;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rsp_q[$];
    logic [3:0] flag_q[$];
    logic [3:0] slot_q[$];
    logic [3:0] flag_dflt;
    int         ev_cnt = 0;

    always #5 MCLK = ~MCLK;

    pc060ha_master_seq #(
        .STROBE_LEN(SL),
        .POLL_MAX  (PM)
    ) u_dut (
        .MCLK     (MCLK),
        .RESET    (RESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_pair (cmd_pair),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .nMCS     (nMCS),
        .nMWR     (nMWR),
        .nMRD     (nMRD),
        .MA0      (MA0),
        .MD_O     (MD_O),
        .MD_OE    (MD_OE),
        .MD_I     (MD_I)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // {valid, wr strobe seen, rd strobe seen, MD_OE, MA0, nibble}
    function automatic logic [8:0] ev(input logic we, input logic a0, input logic [3:0] d);
        return {1'b1, we, ~we, we, a0, d};
    endfunction

    // Slave model and bus monitor for the main instance.
    logic       in_acc = 1'b0;
    logic       a_wr, a_rd, a_oe, a_a0;
    logic [3:0] a_d;
    logic [3:0] idx_m = 4'd0;
    int         s_cnt = 0;
    int         cs_cnt = 0;

    always @(negedge MCLK) begin
        logic [8:0] e;
        if (RESET) begin
            in_acc = 1'b0;
            s_cnt  = 0;
            cs_cnt = 0;
        end else if (!nMCS) begin
            cs_cnt++;
            if (!in_acc) begin
                in_acc = 1'b1;
                s_cnt  = 0;
                a_wr   = 1'b0;
                a_rd   = 1'b0;
                a_oe   = MD_OE;
                a_a0   = MA0;
                a_d    = MD_O;
                if (!MA0 && MD_OE) begin
                    idx_m = MD_O;
                end else if (MA0) begin
                    if (idx_m == 4'd4) begin
                        if (!MD_OE) a_d = (flag_q.size() != 0) ? flag_q.pop_front() : flag_dflt;
                    end else begin
                        if (!MD_OE) a_d = (slot_q.size() != 0) ? slot_q.pop_front() : 4'd0;
                        idx_m = idx_m + 4'd1;
                    end
                end
                if (!MD_OE) MD_I = a_d;
            end
            if (!nMWR) a_wr = 1'b1;
            if (!nMRD) a_rd = 1'b1;
            if (!nMWR || !nMRD) s_cnt++;
        end else if (in_acc) begin
            in_acc = 1'b0;
            ev_cnt++;
            check_eq("strobe_width", s_cnt, SL);
            check_eq("cs_low_len", cs_cnt, SL + 2);
            cs_cnt = 0;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h000;
            check_eq("bus_access", {1'b1, a_wr, a_rd, a_oe, a_a0, a_d}, e);
        end
    end

    always @(negedge MCLK) begin
        logic [8:0] r;
        if (!RESET && rsp_valid) begin
            r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 9'h1FF;
            check_eq("rsp", {rsp_err, rsp_data}, r);
        end
    end

    // Back-to-back SEND streams at other strobe widths.
    for (genvar g = 0; g < 2; g++) begin : g_sl
        localparam int unsigned SLV = (g == 0) ? 1 : 5;
        logic       cr, rv, err, ncs, nwr, nrd, a0, oe;
        logic [7:0] rd;
        logic [3:0] mdo;
        int         lo_cnt, cl_cnt, lat, n_done;
        logic       busy;

        pc060ha_master_seq #(
            .STROBE_LEN(SLV),
            .POLL_MAX  (8)
        ) u_dut6 (
            .MCLK     (MCLK),
            .RESET    (rst6),
            .cmd_valid(cv6),
            .cmd_ready(cr),
            .cmd_op   (2'd0),
            .cmd_pair (1'b0),
            .cmd_data (8'h5A),
            .rsp_valid(rv),
            .rsp_data (rd),
            .rsp_err  (err),
            .nMCS     (ncs),
            .nMWR     (nwr),
            .nMRD     (nrd),
            .MA0      (a0),
            .MD_O     (mdo),
            .MD_OE    (oe),
            .MD_I     (4'h0)
        );

        always @(negedge MCLK) begin
            if (rst6) begin
                lo_cnt = 0;
                cl_cnt = 0;
                lat    = 0;
                n_done = 0;
                busy   = 1'b0;
            end else begin
                if (!nwr || !nrd) lo_cnt++;
                else if (lo_cnt != 0) begin
                    check_eq("s6_strobe_width", lo_cnt, SLV);
                    lo_cnt = 0;
                end
                if (!ncs) cl_cnt++;
                else if (cl_cnt != 0) begin
                    check_eq("s6_cs_low_len", cl_cnt, SLV + 2);
                    cl_cnt = 0;
                end
                if (busy) begin
                    lat++;
                    check_eq("s6_ready_busy", cr, 1'b0);
                    if (rv) begin
                        busy = 1'b0;
                        n_done++;
                        check_eq("s6_latency", (lat - 1 >= 5 * (SLV + 3) - 1) &&
                                               (lat - 1 <= 5 * (SLV + 3) + 1), 1'b1);
                        check_eq("s6_rsp", {err, rd}, 9'h000);
                    end
                end else if (cv6 && cr) begin
                    busy = 1'b1;
                    lat  = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic pair, input logic [7:0] data);
        int n;
        @(negedge MCLK);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_pair  = pair;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge MCLK);
            n++;
        end
        check_eq("accept_in_time", n < 200, 1'b1);
        @(posedge MCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_pair  = ~pair;
        cmd_data  = ~data;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < 3000) begin
            @(negedge MCLK);
            n++;
        end
        check_eq("drain_in_time", n < 3000, 1'b1);
        repeat (3) @(negedge MCLK);
    endtask

    initial begin
        int n;
        int base;
        RESET     = 1'b1;
        rst6      = 1'b1;
        cv6       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_pair  = 1'b0;
        cmd_data  = 8'd0;
        MD_I      = 4'd0;
        flag_dflt = 4'd0;
        repeat (3) @(negedge MCLK);
        check_eq("rst_nmcs", nMCS, 1'b1);
        check_eq("rst_nmwr", nMWR, 1'b1);
        check_eq("rst_nmrd", nMRD, 1'b1);
        check_eq("rst_ma0", MA0, 1'b0);
        check_eq("rst_md", {MD_OE, MD_O}, 5'd0);
        check_eq("rst_ready", cmd_ready, 1'b0);
        check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 10'd0);
        RESET = 1'b0;
        @(negedge MCLK);
        check_eq("ready_idle", cmd_ready, 1'b1);

        // SEND pair0 0xA5, flag clear
        exp_q = '{ev(1, 0, 4'h4), ev(0, 1, 4'h0), ev(1, 0, 4'h0), ev(1, 1, 4'h5), ev(1, 1, 4'hA)};
        rsp_q.push_back(9'h000);
        issue(2'd0, 1'b0, 8'hA5);
        drain();

        // RECV pair1, slave slot fills on the third poll
        flag_q = '{4'h0, 4'h0, 4'h8};
        slot_q = '{4'h3, 4'hC};
        exp_q = '{ev(1, 0, 4'h4), ev(0, 1, 4'h0), ev(0, 1, 4'h0), ev(0, 1, 4'h8),
                  ev(1, 0, 4'h2), ev(0, 1, 4'h3), ev(0, 1, 4'hC)};
        rsp_q.push_back({1'b0, 8'hC3});
        issue(2'd1, 1'b1, 8'h00);
        drain();

        // SEND pair1 with master slot stuck pending: timeout
        flag_dflt = 4'h2;
        exp_q = '{ev(1, 0, 4'h4), ev(0, 1, 4'h2), ev(0, 1, 4'h2), ev(0, 1, 4'h2), ev(0, 1, 4'h2)};
        rsp_q.push_back({1'b1, 8'h00});
        issue(2'd0, 1'b1, 8'h77);
        drain();
        flag_dflt = 4'h0;

        // Slave reset set / clear
        exp_q = '{ev(1, 0, 4'h4), ev(1, 1, 4'h1)};
        rsp_q.push_back(9'h000);
        issue(2'd2, 1'b0, 8'hFF);
        drain();
        exp_q = '{ev(1, 0, 4'h4), ev(1, 1, 4'h0)};
        rsp_q.push_back(9'h000);
        issue(2'd3, 1'b1, 8'hFF);
        drain();

        // Reset during the D0 write strobe
        base  = ev_cnt;
        exp_q = '{ev(1, 0, 4'h4), ev(0, 1, 4'h0), ev(1, 0, 4'h0)};
        issue(2'd0, 1'b0, 8'h3C);
        n = 0;
        while (!(ev_cnt == base + 3 && !nMWR) && n < 500) begin
            @(negedge MCLK);
            n++;
        end
        check_eq("d0_strobe_reached", n < 500, 1'b1);
        #1 RESET = 1'b1;
        #1;
        check_eq("arst_nmwr", nMWR, 1'b1);
        check_eq("arst_nmcs", nMCS, 1'b1);
        check_eq("arst_ready", cmd_ready, 1'b0);
        repeat (3) @(negedge MCLK);
        RESET = 1'b0;
        @(negedge MCLK);
        check_eq("post_rst_ready", cmd_ready, 1'b1);
        check_eq("pre_rst_trace_left", exp_q.size(), 0);
        exp_q = '{ev(1, 0, 4'h4), ev(0, 1, 4'h0), ev(1, 0, 4'h2), ev(1, 1, 4'h6), ev(1, 1, 4'h9)};
        rsp_q.push_back(9'h000);
        issue(2'd0, 1'b1, 8'h96);
        drain();

        // Back-to-back SEND streams at STROBE_LEN 1 and 5
        @(negedge MCLK);
        rst6 = 1'b0;
        cv6  = 1'b1;
        n = 0;
        while ((g_sl[0].n_done < 3 || g_sl[1].n_done < 3) && n < 3000) begin
            @(negedge MCLK);
            n++;
        end
        check_eq("stream_in_time", n < 3000, 1'b1);
        cv6 = 1'b0;
        repeat (80) @(negedge MCLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
